// File: rtl/top_score_ctrl.sv
// Per-mode leaderboard: submitted scores are inserted in sorted order; display reads one ranked entry at a time.
// Insert takes 6 cycles from acceptance to upd_done; reads ack the cycle after acceptance. Requests seen outside IDLE are dropped.
module top_score_ctrl #(
    parameter int MODES   = 3,
    parameter int ENTRIES = 4,
    parameter int SCORE_W = 7,
    parameter int PID_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_req,
    input  logic               upd_req,
    input  logic [1:0]         upd_mode,
    input  logic [PID_W-1:0]   upd_pid,
    input  logic               upd_guest,
    input  logic [SCORE_W-1:0] upd_score,
    output logic               upd_busy,
    output logic               upd_done,
    output logic               upd_placed,
    output logic [1:0]         upd_rank,
    input  logic               rd_req,
    input  logic [1:0]         rd_mode,
    input  logic [1:0]         rd_idx,
    output logic               rd_ack,
    output logic               rd_hit,
    output logic [PID_W-1:0]   rd_pid,
    output logic               rd_guest,
    output logic [SCORE_W-1:0] rd_score
);

    typedef struct packed {
        logic               valid;
        logic [PID_W-1:0]   pid;
        logic               guest;
        logic [SCORE_W-1:0] score;
    } rec_t;

    typedef enum logic [2:0] {IDLE, SCAN, SHIFT, WRITE, DONE} state_t;

    localparam logic [2:0] MODE_LIM = 3'(MODES);
    localparam logic [2:0] ENT_LIM  = 3'(ENTRIES);
    localparam logic [1:0] LAST     = 2'(ENTRIES - 1);

    state_t     state;
    rec_t       tbl [MODES][ENTRIES];
    rec_t       cur;
    rec_t       scan_rec;
    logic [1:0] cur_mode;
    logic [1:0] idx;
    logic [1:0] pos;
    logic [1:0] j;
    logic       upd_mode_bad;
    logic       rd_oob;
    logic       scan_hit;

    assign upd_mode_bad = ({1'b0, upd_mode} >= MODE_LIM);
    assign rd_oob       = ({1'b0, rd_mode} >= MODE_LIM) || ({1'b0, rd_idx} >= ENT_LIM);

    // cur_mode is only in range while an update is in flight, so guard the lookup.
    always_comb begin
        scan_rec = '0;
        if ({1'b0, cur_mode} < MODE_LIM) begin
            scan_rec = tbl[cur_mode][idx];
        end
    end

    // Strict compare: an equal score ranks below the entry already there.
    assign scan_hit = !scan_rec.valid || (cur.score > scan_rec.score);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            cur_mode   <= '0;
            idx        <= '0;
            pos        <= '0;
            j          <= '0;
            upd_busy   <= 1'b0;
            upd_done   <= 1'b0;
            upd_placed <= 1'b0;
            upd_rank   <= '0;
            rd_ack     <= 1'b0;
            rd_hit     <= 1'b0;
            rd_pid     <= '0;
            rd_guest   <= 1'b0;
            rd_score   <= '0;
            for (int m = 0; m < MODES; m++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    tbl[m][e] <= '0;
                end
            end
        end else begin
            upd_done <= 1'b0;
            rd_ack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        for (int m = 0; m < MODES; m++) begin
                            for (int e = 0; e < ENTRIES; e++) begin
                                tbl[m][e].valid <= 1'b0;
                            end
                        end
                    end else if (upd_req) begin
                        cur      <= '{valid: 1'b1, pid: upd_pid, guest: upd_guest, score: upd_score};
                        cur_mode <= upd_mode;
                        idx      <= '0;
                        upd_busy <= 1'b1;
                        if (upd_mode_bad) begin
                            upd_done   <= 1'b1;
                            upd_placed <= 1'b0;
                            upd_rank   <= '0;
                            state      <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end else if (rd_req && !rd_ack) begin
                        // The requester holds rd_req through the ack cycle; skip it to avoid a double ack.
                        rd_ack <= 1'b1;
                        if (rd_oob) begin
                            rd_hit   <= 1'b0;
                            rd_pid   <= '0;
                            rd_guest <= 1'b0;
                            rd_score <= '0;
                        end else begin
                            rd_hit   <= tbl[rd_mode][rd_idx].valid;
                            rd_pid   <= tbl[rd_mode][rd_idx].pid;
                            rd_guest <= tbl[rd_mode][rd_idx].guest;
                            rd_score <= tbl[rd_mode][rd_idx].score;
                        end
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        pos   <= idx;
                        j     <= LAST;
                        state <= (idx == LAST) ? WRITE : SHIFT;
                    end else if (idx == LAST) begin
                        upd_done   <= 1'b1;
                        upd_placed <= 1'b0;
                        upd_rank   <= '0;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                SHIFT: begin
                    // Moving bottom-up lets the lowest entry fall off without a temporary.
                    tbl[cur_mode][j] <= tbl[cur_mode][j - 2'd1];
                    j <= j - 2'd1;
                    if ((j - 2'd1) == pos) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    tbl[cur_mode][pos] <= cur;
                    upd_done   <= 1'b1;
                    upd_placed <= 1'b1;
                    upd_rank   <= pos;
                    state      <= DONE;
                end
                DONE: begin
                    upd_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_score_ctrl.sv
// Directed bench for top_score_ctrl: inserts, evictions, ties, arbitration, clear and reset mid-update.
module tb_top_score_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_req;
    logic       upd_req;
    logic [1:0] upd_mode;
    logic [2:0] upd_pid;
    logic       upd_guest;
    logic [6:0] upd_score;
    logic       upd_busy;
    logic       upd_done;
    logic       upd_placed;
    logic [1:0] upd_rank;
    logic       rd_req;
    logic [1:0] rd_mode;
    logic [1:0] rd_idx;
    logic       rd_ack;
    logic       rd_hit;
    logic [2:0] rd_pid;
    logic       rd_guest;
    logic [6:0] rd_score;

    int checks = 0;
    int errors = 0;

    top_score_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .upd_req   (upd_req),
        .upd_mode  (upd_mode),
        .upd_pid   (upd_pid),
        .upd_guest (upd_guest),
        .upd_score (upd_score),
        .upd_busy  (upd_busy),
        .upd_done  (upd_done),
        .upd_placed(upd_placed),
        .upd_rank  (upd_rank),
        .rd_req    (rd_req),
        .rd_mode   (rd_mode),
        .rd_idx    (rd_idx),
        .rd_ack    (rd_ack),
        .rd_hit    (rd_hit),
        .rd_pid    (rd_pid),
        .rd_guest  (rd_guest),
        .rd_score  (rd_score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_upd(input logic [1:0] m, input logic [2:0] p, input logic g,
                          input logic [6:0] s, input logic ep, input logic [1:0] er,
                          input int elat, input string tag);
        int n;
        @(negedge clk);
        upd_mode = m; upd_pid = p; upd_guest = g; upd_score = s; upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        n = 1;
        chk({tag, " busy"}, upd_busy, 1);
        while (!upd_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, elat);
        chk({tag, " placed"}, upd_placed, ep);
        if (ep) chk({tag, " rank"}, upd_rank, er);
        @(negedge clk);
        chk({tag, " busy drop"}, upd_busy, 0);
    endtask

    task automatic do_rd(input logic [1:0] m, input logic [1:0] i, input logic eh,
                         input logic chk_data, input logic [6:0] es, input logic [2:0] ep,
                         input logic eg, input string tag);
        int n;
        @(negedge clk);
        rd_mode = m; rd_idx = i; rd_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_ack && n < 20);
        rd_req = 1'b0;
        chk({tag, " ack latency"}, n, 1);
        chk({tag, " hit"}, rd_hit, eh);
        if (chk_data) begin
            chk({tag, " score"}, rd_score, es);
            chk({tag, " pid"}, rd_pid, ep);
            chk({tag, " guest"}, rd_guest, eg);
        end
    endtask

    initial begin
        int n;
        int early;
        int dones;
        rst = 1'b1; clr_req = 1'b0; upd_req = 1'b0; upd_mode = '0; upd_pid = '0;
        upd_guest = 1'b0; upd_score = '0; rd_req = 1'b0; rd_mode = '0; rd_idx = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", upd_busy, 0);
        chk("reset done", upd_done, 0);
        chk("reset placed", upd_placed, 0);
        chk("reset ack", rd_ack, 0);
        chk("reset score", rd_score, 0);
        rst = 1'b0;

        do_rd(2'd0, 2'd0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, "empty read");
        do_rd(2'd3, 2'd1, 1'b0, 1'b1, 7'd0, 3'd0, 1'b0, "bad mode read");

        do_upd(2'd1, 3'd2, 1'b0, 7'd20, 1'b1, 2'd0, 6, "first insert");
        do_rd(2'd1, 2'd0, 1'b1, 1'b1, 7'd20, 3'd2, 1'b0, "first read");

        // Build mode 1 = {40,30,20,10}
        do_upd(2'd1, 3'd1, 1'b0, 7'd40, 1'b1, 2'd0, 6, "ins 40");
        do_upd(2'd1, 3'd3, 1'b0, 7'd30, 1'b1, 2'd1, 6, "ins 30");
        do_upd(2'd1, 3'd6, 1'b1, 7'd10, 1'b1, 2'd3, 6, "ins 10");
        do_rd(2'd1, 2'd3, 1'b1, 1'b1, 7'd10, 3'd6, 1'b1, "bottom 10");
        do_upd(2'd1, 3'd5, 1'b0, 7'd25, 1'b1, 2'd2, 6, "ins 25");
        do_rd(2'd1, 2'd0, 1'b1, 1'b1, 7'd40, 3'd1, 1'b0, "m1 r0");
        do_rd(2'd1, 2'd1, 1'b1, 1'b1, 7'd30, 3'd3, 1'b0, "m1 r1");
        do_rd(2'd1, 2'd2, 1'b1, 1'b1, 7'd25, 3'd5, 1'b0, "m1 r2");
        do_rd(2'd1, 2'd3, 1'b1, 1'b1, 7'd20, 3'd2, 1'b0, "m1 r3 evict");
        do_upd(2'd1, 3'd7, 1'b0, 7'd5, 1'b0, 2'd0, 5, "ins 5 miss");
        do_rd(2'd1, 2'd3, 1'b1, 1'b1, 7'd20, 3'd2, 1'b0, "m1 r3 unchanged");

        // Tie keeps the older entry above
        do_upd(2'd0, 3'd1, 1'b0, 7'd15, 1'b1, 2'd0, 6, "tie first");
        do_upd(2'd0, 3'd4, 1'b0, 7'd15, 1'b1, 2'd1, 6, "tie second");
        do_rd(2'd0, 2'd0, 1'b1, 1'b1, 7'd15, 3'd1, 1'b0, "tie r0");
        do_rd(2'd0, 2'd1, 1'b1, 1'b1, 7'd15, 3'd4, 1'b0, "tie r1");

        do_upd(2'd3, 3'd1, 1'b0, 7'd99, 1'b0, 2'd0, 1, "bad mode upd");

        // Update wins over a simultaneous read; the held read is served afterwards
        @(negedge clk);
        upd_mode = 2'd2; upd_pid = 3'd7; upd_guest = 1'b1; upd_score = 7'd50; upd_req = 1'b1;
        rd_mode = 2'd2; rd_idx = 2'd0; rd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        n = 1; early = 0;
        while (!upd_done && n < 20) begin
            if (rd_ack) early++;
            @(negedge clk);
            n++;
        end
        if (rd_ack) early++;
        chk("arb latency", n, 6);
        chk("arb no ack while busy", early, 0);
        chk("arb rank", upd_rank, 0);
        @(negedge clk);
        chk("arb busy drop", upd_busy, 0);
        chk("arb ack not yet", rd_ack, 0);
        @(negedge clk);
        chk("arb ack", rd_ack, 1);
        chk("arb hit", rd_hit, 1);
        chk("arb score", rd_score, 50);
        chk("arb pid", rd_pid, 7);
        chk("arb guest", rd_guest, 1);
        rd_req = 1'b0;

        // Clear beats update
        @(negedge clk);
        clr_req = 1'b1; upd_req = 1'b1; upd_mode = 2'd1; upd_score = 7'd60;
        @(negedge clk);
        clr_req = 1'b0; upd_req = 1'b0;
        chk("clr busy", upd_busy, 0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (upd_done || upd_busy) dones++;
        end
        chk("clr no update", dones, 0);
        do_rd(2'd1, 2'd0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, "clr m1");
        do_rd(2'd0, 2'd0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, "clr m0");

        // Reset during SHIFT abandons the update
        do_upd(2'd0, 3'd2, 1'b0, 7'd30, 1'b1, 2'd0, 6, "pre-rst ins");
        @(negedge clk);
        upd_mode = 2'd0; upd_pid = 3'd3; upd_score = 7'd50; upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy", upd_busy, 0);
        chk("rst done", upd_done, 0);
        chk("rst placed", upd_placed, 0);
        chk("rst rank", upd_rank, 0);
        chk("rst score", rd_score, 0);
        chk("rst pid", rd_pid, 0);
        rst = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (upd_done) dones++;
        end
        chk("rst no done", dones, 0);
        do_rd(2'd0, 2'd0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, "rst m0 r0");
        do_rd(2'd0, 2'd1, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, "rst m0 r1");
        do_rd(2'd2, 2'd0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, "rst m2 r0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
